// File: rtl/add_sub_pkg.sv
// ---------------------------------------------------------------------------
// add_sub_pkg
// Shared types and constants for the digit-serial adder/subtractor.
//   state_t  : controller states (IDLE, RUN, DONE)
//   MODE_ADD : control value selecting A+B
//   MODE_SUB : control value selecting A-B
// ---------------------------------------------------------------------------
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/add_sub_digit.sv
// ---------------------------------------------------------------------------
// add_sub_digit
// Combinational DIGIT-bit two's-complement add/subtract slice.
// In subtract mode the B slice is one's-complemented here; the "+1" comes in
// through ci on the least significant slice.
// Ports:
//   a, b    : DIGIT-bit operand slices
//   ci      : carry into the slice
//   control : 0 = add, 1 = subtract
//   s       : DIGIT-bit sum slice
//   co      : carry out of the slice
//   c_msb   : carry into the slice's top bit (used for signed overflow)
// ---------------------------------------------------------------------------
module add_sub_digit
    import add_sub_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    input  logic             control,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT-1:0] b_mod;
    logic [DIGIT:0]   sum;

    assign b_mod = b ^ {DIGIT{control == MODE_SUB}};
    assign sum   = {1'b0, a} + {1'b0, b_mod} + {{DIGIT{1'b0}}, ci};
    assign s     = sum[DIGIT-1:0];
    assign co    = sum[DIGIT];
    // Top sum bit is a^b^c_in, so the carry into it can be recovered directly.
    assign c_msb = s[DIGIT-1] ^ a[DIGIT-1] ^ b_mod[DIGIT-1];

endmodule

// File: rtl/digit_serial_add_sub.sv
// ---------------------------------------------------------------------------
// digit_serial_add_sub
// Multi-cycle two's-complement adder/subtractor. WIDTH-bit operands are
// processed one DIGIT-bit slice per clock, LSB slice first, through a single
// reused add_sub_digit slice with a registered carry between slices.
// After the last slice, one further cycle registers the flags (and the
// optional clamp), so out_valid rises NDIG+1 cycles after the accept edge.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operation handshake (accepted only in IDLE)
//   a, b, control       : operands and mode (0 = A+B, 1 = A-B)
//   out_valid, out_ready: result handshake (held until out_ready)
//   result              : WIDTH-bit sum/difference (modulo 2^WIDTH)
//   carry               : MSB carry-out; for subtract 1 means no borrow
//   overflow            : signed overflow
//   zero                : result == 0
// Optional feature: define ADD_SUB_SATURATE_EN to clamp the result to the
// most positive/negative value on signed overflow (flags stay raw, zero is
// computed on the clamped value).
// ---------------------------------------------------------------------------
module digit_serial_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NDIG - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             ctrl_q;
    logic [CNT_W-1:0] idx;
    logic             carry_reg;
    logic             c_msb;

    logic [DIGIT-1:0] a_sl;
    logic [DIGIT-1:0] b_sl;
    logic [DIGIT-1:0] s_sl;
    logic             co_sl;
    logic             cm_sl;

    logic             accept;
    logic             last;
    logic             finish;
    logic             retire;
    logic             ov_raw;
    logic [WIDTH-1:0] res_final;

`ifdef ADD_SUB_SATURATE_EN
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] r,
                                                  input logic             ov,
                                                  input logic             a_msb);
        if (!ov) return r;
        // Overflow direction follows the sign of A: positive A clamps high.
        return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    assign accept = in_valid && in_ready;
    assign last   = (idx == LAST_IDX);
    // First DONE cycle registers flags; later DONE cycles only wait.
    assign finish = (state == DONE) && !out_valid;
    assign retire = (state == DONE) && out_valid && out_ready;
    assign ov_raw = carry_reg ^ c_msb;

`ifdef ADD_SUB_SATURATE_EN
    assign res_final = saturate(result, ov_raw, a_q[WIDTH-1]);
`else
    assign res_final = result;
`endif

    // Slice selection by digit index.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (idx == CNT_W'(k)) begin
                a_sl = a_q[k*DIGIT +: DIGIT];
                b_sl = b_q[k*DIGIT +: DIGIT];
            end
        end
    end

    add_sub_digit #(.DIGIT(DIGIT)) u_digit (
        .a       (a_sl),
        .b       (b_sl),
        .ci      (carry_reg),
        .control (ctrl_q),
        .s       (s_sl),
        .co      (co_sl),
        .c_msb   (cm_sl)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN:     if (last) state_next = DONE;
            DONE:    if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= 1'b0;
            idx       <= '0;
            carry_reg <= 1'b0;
            c_msb     <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                a_q       <= a;
                b_q       <= b;
                ctrl_q    <= control;
                carry_reg <= control;   // +1 of two's-complement negate
                idx       <= '0;
            end
            if (state == RUN) begin
                for (int k = 0; k < NDIG; k++) begin
                    if (idx == CNT_W'(k)) result[k*DIGIT +: DIGIT] <= s_sl;
                end
                carry_reg <= co_sl;
                idx       <= idx + 1'b1;
                if (last) c_msb <= cm_sl;
            end
            if (finish) begin
                result    <= res_final;
                carry     <= carry_reg;
                overflow  <= ov_raw;
                zero      <= (res_final == '0);
                out_valid <= 1'b1;
            end
            if (retire) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_digit_serial_add_sub.sv
// ---------------------------------------------------------------------------
// tb_digit_serial_add_sub
// Bench for digit_serial_add_sub with WIDTH=16 at DIGIT=4, 1 and 16
// (instances 0, 1, 2). Expected results come from a behavioural model and
// are queued at issue time, popped when out_valid is seen.
// Honours ADD_SUB_SATURATE_EN in the model.
// ---------------------------------------------------------------------------
module tb_digit_serial_add_sub;
    import add_sub_pkg::*;

    typedef struct packed {
        logic [15:0] r;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        control = 1'b0;
    logic        iv   [3];
    logic        ordy [3];
    logic        rdy  [3];
    logic        ovd  [3];
    logic [15:0] res  [3];
    logic        cy   [3];
    logic        ov   [3];
    logic        zr   [3];

    exp_t sb[$];
    exp_t e;
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DG = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
        digit_serial_add_sub #(.WIDTH(16), .DIGIT(DG)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (rdy[g]),
            .a         (a),
            .b         (b),
            .control   (control),
            .out_valid (ovd[g]),
            .out_ready (ordy[g]),
            .result    (res[g]),
            .carry     (cy[g]),
            .overflow  (ov[g]),
            .zero      (zr[g])
        );
    end

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic sub);
        exp_t        m;
        logic [16:0] s;
        logic [15:0] yy;
        yy  = sub ? ~y : y;
        s   = {1'b0, x} + {1'b0, yy} + {16'd0, sub};
        m.r = s[15:0];
        m.c = s[16];
        if (sub) m.v = (x[15] != y[15]) && (m.r[15] != x[15]);
        else     m.v = (x[15] == y[15]) && (m.r[15] != x[15]);
`ifdef ADD_SUB_SATURATE_EN
        if (m.v) m.r = x[15] ? 16'h8000 : 16'h7FFF;
`endif
        m.z = (m.r == 16'h0000);
        return m;
    endfunction

    task automatic send_op(input int k, input logic [15:0] x, input logic [15:0] y,
                           input logic sub);
        @(negedge clk);
        a = x; b = y; control = sub; iv[k] = 1'b1;
        sb.push_back(model(x, y, sub));
        @(posedge clk);
        #1 iv[k] = 1'b0;
    endtask

    task automatic wait_out(input int k, output int cyc);
        cyc = 0;
        while (!ovd[k] && cyc < 40) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic retire_out(input int k);
        ordy[k] = 1'b1;
        @(posedge clk);
        #1 ordy[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if ({rdy[k], ovd[k], res[k], cy[k], ov[k], zr[k]} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
                n_fail++;
                $display("FAIL reset[%0d]: got rdy=%b ov_valid=%b res=%h c=%b v=%b z=%b, want rdy=1 others 0",
                         k, rdy[k], ovd[k], res[k], cy[k], ov[k], zr[k]);
            end
        end
    endtask

    task automatic test_sub_basic();
        int cyc;
        send_op(0, 16'h0003, 16'h0002, MODE_SUB);
        wait_out(0, cyc);
        n_vec++;
        if (cyc !== 5) begin n_fail++; $display("FAIL sub_basic latency: got %0d, want 5", cyc); end
        e = sb.pop_front();
        n_vec++;
        if ({res[0], cy[0], ov[0], zr[0]} !== {16'h0001, 3'b100} || e !== {16'h0001, 3'b100}) begin
            n_fail++;
            $display("FAIL sub_basic out: got %h c=%b v=%b z=%b, want 0001 c=1 v=0 z=0",
                     res[0], cy[0], ov[0], zr[0]);
        end
        retire_out(0);
        n_vec++;
        if (ovd[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_basic retire: got ov_valid=%b rdy=%b, want 0 1", ovd[0], rdy[0]);
        end
    endtask

    task automatic test_overflow();
        int cyc;
        send_op(0, 16'h7FFF, 16'h0001, MODE_ADD);
        wait_out(0, cyc);
        e = sb.pop_front();
        n_vec++;
        if ({res[0], cy[0], ov[0], zr[0]} !== e || e.v !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow out: got %h c=%b v=%b z=%b, want %h c=%b v=%b z=%b",
                     res[0], cy[0], ov[0], zr[0], e.r, e.c, e.v, e.z);
        end
        retire_out(0);
    endtask

    task automatic test_negative_and_zero();
        int cyc;
        send_op(0, 16'h0005, 16'h000A, MODE_SUB);
        wait_out(0, cyc);
        e = sb.pop_front();
        n_vec++;
        if ({res[0], cy[0], ov[0], zr[0]} !== {16'hFFFB, 3'b000}) begin
            n_fail++;
            $display("FAIL negative out: got %h c=%b v=%b z=%b, want fffb c=0 v=0 z=0",
                     res[0], cy[0], ov[0], zr[0]);
        end
        retire_out(0);
        send_op(0, 16'hFFFF, 16'h0001, MODE_ADD);
        wait_out(0, cyc);
        e = sb.pop_front();
        n_vec++;
        if ({res[0], cy[0], ov[0], zr[0]} !== {16'h0000, 3'b101}) begin
            n_fail++;
            $display("FAIL zero out: got %h c=%b v=%b z=%b, want 0000 c=1 v=0 z=1",
                     res[0], cy[0], ov[0], zr[0]);
        end
        retire_out(0);
    endtask

    task automatic test_backpressure();
        int cyc;
        send_op(0, 16'h1234, 16'h0234, MODE_SUB);
        wait_out(0, cyc);
        n_vec++;
        if (cyc !== 5) begin n_fail++; $display("FAIL backpressure latency: got %0d, want 5", cyc); end
        e = sb[0];
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                @(negedge clk);
                a = 16'hAAAA; b = 16'h5555; iv[0] = 1'b1;
                @(posedge clk);
                #1 iv[0] = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
            n_vec++;
            if ({ovd[0], rdy[0], res[0], cy[0], ov[0], zr[0]} !== {1'b1, 1'b0, e}) begin
                n_fail++;
                $display("FAIL backpressure hold[%0d]: got ov_valid=%b rdy=%b %h c=%b v=%b z=%b, want 1 0 %h c=%b v=%b z=%b",
                         i, ovd[0], rdy[0], res[0], cy[0], ov[0], zr[0], e.r, e.c, e.v, e.z);
            end
        end
        void'(sb.pop_front());
        retire_out(0);
        repeat (8) @(posedge clk);
        #1;
        n_vec++;
        if (ovd[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure ignored_input: got ov_valid=%b rdy=%b, want 0 1", ovd[0], rdy[0]);
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        send_op(0, 16'h1234, 16'h1111, MODE_ADD);
        void'(sb.pop_front());
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n_vec++;
        if ({rdy[0], ovd[0], res[0], cy[0], ov[0], zr[0]} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
            n_fail++;
            $display("FAIL abort state: got rdy=%b ov_valid=%b res=%h c=%b v=%b z=%b, want rdy=1 others 0",
                     rdy[0], ovd[0], res[0], cy[0], ov[0], zr[0]);
        end
        send_op(0, 16'h1234, 16'h1111, MODE_ADD);
        wait_out(0, cyc);
        n_vec++;
        if (cyc !== 5) begin n_fail++; $display("FAIL abort latency: got %0d, want 5", cyc); end
        e = sb.pop_front();
        n_vec++;
        if ({res[0], cy[0], ov[0], zr[0]} !== {16'h2345, 3'b000}) begin
            n_fail++;
            $display("FAIL abort rerun: got %h c=%b v=%b z=%b, want 2345 c=0 v=0 z=0",
                     res[0], cy[0], ov[0], zr[0]);
        end
        retire_out(0);
    endtask

    task automatic test_sweep(input int k, input int lat);
        int          cyc;
        logic [15:0] x, y;
        logic        sub;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0:       begin x = 16'h8000; y = 16'h0001; sub = MODE_SUB; end
                1:       begin x = 16'h7FFF; y = 16'h7FFF; sub = MODE_ADD; end
                2:       begin x = 16'h0000; y = 16'h0000; sub = MODE_SUB; end
                default: begin x = 16'($urandom); y = 16'($urandom); sub = 1'($urandom_range(0, 1)); end
            endcase
            send_op(k, x, y, sub);
            wait_out(k, cyc);
            n_vec++;
            if (cyc !== lat) begin
                n_fail++;
                $display("FAIL sweep[%0d] latency: got %0d, want %0d", k, cyc, lat);
            end
            e = sb.pop_front();
            n_vec++;
            if ({res[k], cy[k], ov[k], zr[k]} !== e) begin
                n_fail++;
                $display("FAIL sweep[%0d] %h %s %h: got %h c=%b v=%b z=%b, want %h c=%b v=%b z=%b",
                         k, x, sub ? "-" : "+", y, res[k], cy[k], ov[k], zr[k], e.r, e.c, e.v, e.z);
            end
            retire_out(k);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            iv[k]   = 1'b0;
            ordy[k] = 1'b0;
        end
        test_reset();
        test_sub_basic();
        test_overflow();
        test_negative_and_zero();
        test_backpressure();
        test_reset_abort();
        test_sweep(1, 17);
        test_sweep(2, 2);
        test_sweep(0, 5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
